gfx_rom_fetch: RTL and testbench

GFX_ROM_FETCH -- requirements
Module: gfx_rom_fetch

---
 rtl/gfx_fetch_pkg.sv | 25 ++
 rtl/gfx_port_tag.sv | 59 +++++
 rtl/gfx_rom_fetch.sv | 153 +++++++++++++++
 tb/tb_gfx_rom_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_fetch_pkg.sv
// gfx_fetch_pkg
//   Shared types and constants for the graphics ROM fetch block.
//   - fetch_state_t : FSM state encoding for gfx_rom_fetch
//   - REGION_CHAR / REGION_SPR : region bit prepended to the external address
//   - ERR_MAX : saturation value of the timeout error counter
//   - sat_inc8 : saturating 8-bit increment used by err_cnt

package gfx_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHAR_WAIT = 2'd1,
    ST_SPR_WAIT  = 2'd2,
    ST_BACKOFF   = 2'd3
  } fetch_state_t;

  localparam logic       REGION_CHAR = 1'b0;
  localparam logic       REGION_SPR  = 1'b1;
  localparam logic [7:0] ERR_MAX     = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == ERR_MAX) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/gfx_port_tag.sv
// gfx_port_tag
//   Per-port fetch bookkeeping: tag (address of the last launched fetch),
//   valid bit and the two bitplane data registers.
//   Ports:
//     clk_sys, reset_n       : clock, synchronous active-low reset
//     rom_addr   [ADDR_W-1:0]: current tile-row address requested by video
//     load_tag               : capture rom_addr into the tag (fetch launched)
//     load_data              : capture mem_data into data1/data2, set valid
//     clr_valid              : invalidate after a timed-out fetch
//     mem_data   [15:0]      : {plane 2, plane 1} from external memory
//     dirty                  : port needs a fetch (invalid or address moved)
//     data1, data2 [7:0]     : registered bitplane outputs

module gfx_port_tag
  import gfx_fetch_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic              load_tag,
  input  logic              load_data,
  input  logic              clr_valid,
  input  logic [15:0]       mem_data,
  output logic              dirty,
  output logic [7:0]        data1,
  output logic [7:0]        data2
);

  logic [ADDR_W-1:0] tag;
  logic              valid;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tag   <= '0;
      valid <= 1'b0;
      data1 <= 8'd0;
      data2 <= 8'd0;
    end else begin
      if (load_tag) begin
        tag <= rom_addr;
      end
      if (load_data) begin
        data1 <= mem_data[7:0];
        data2 <= mem_data[15:8];
        valid <= 1'b1;
      end else if (clr_valid) begin
        valid <= 1'b0;
      end
    end
  end

  // The tag already holds the in-flight address while a fetch is pending, so
  // an address change during the fetch still shows up as dirty once the
  // fetch returns and the FSM is back in IDLE.
  assign dirty = !valid || (rom_addr != tag);

endmodule

// File: rtl/gfx_rom_fetch.sv
// gfx_rom_fetch
//   Arbitrates character and sprite tile-row fetches onto a single external
//   16-bit graphics ROM port. Each port refetches whenever its address moves
//   or its last fetch failed; char has priority over sprite.
//   Ports:
//     clk_sys, reset_n            : clock, synchronous active-low reset
//     char_rom_addr [ADDR_W-1:0]  : character tile-row address
//     char_data1/2  [7:0]         : character bitplanes 1 / 2
//     spr_rom_addr  [ADDR_W-1:0]  : sprite tile-row address
//     spr_data1/2   [7:0]         : sprite bitplanes 1 / 2
//     mem_addr      [ADDR_W:0]    : {region, addr}, region 0 = char, 1 = sprite
//     mem_req                     : read request level, held until ack/timeout
//     mem_ack                     : one-cycle acknowledge, mem_data valid with it
//     mem_data      [15:0]        : {plane 2, plane 1}
//     err_cnt       [7:0]         : saturating count of fetch timeouts
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | no fetch in flight; launch char if dirty, else sprite
//   CHAR_WAIT  | char fetch outstanding, waiting for mem_ack or timeout
//   SPR_WAIT   | sprite fetch outstanding, waiting for mem_ack or timeout
//   BACKOFF    | one quiet cycle after a timeout before re-arbitrating

module gfx_rom_fetch
  import gfx_fetch_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 31
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] char_rom_addr,
  output logic [7:0]        char_data1,
  output logic [7:0]        char_data2,
  input  logic [ADDR_W-1:0] spr_rom_addr,
  output logic [7:0]        spr_data1,
  output logic [7:0]        spr_data2,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [7:0]        err_cnt
);

  // Down-counter loaded on launch; the wait cycle that sees zero without an
  // ack is the TIMEOUT-th one, so mem_req is high for exactly TIMEOUT cycles.
  localparam int              CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);

  fetch_state_t     state;
  logic [CNT_W-1:0] wait_cnt;

  logic char_dirty;
  logic spr_dirty;
  logic wait_tc;

  logic char_load_tag;
  logic spr_load_tag;
  logic char_load_data;
  logic spr_load_data;
  logic char_clr_valid;
  logic spr_clr_valid;

  assign wait_tc = (wait_cnt == '0);

  // Port strobes mirror the FSM decisions made in the same cycle below.
  assign char_load_tag  = (state == ST_IDLE) && char_dirty;
  assign spr_load_tag   = (state == ST_IDLE) && !char_dirty && spr_dirty;
  assign char_load_data = (state == ST_CHAR_WAIT) && mem_ack;
  assign spr_load_data  = (state == ST_SPR_WAIT) && mem_ack;
  assign char_clr_valid = (state == ST_CHAR_WAIT) && !mem_ack && wait_tc;
  assign spr_clr_valid  = (state == ST_SPR_WAIT) && !mem_ack && wait_tc;

  gfx_port_tag #(
    .ADDR_W (ADDR_W)
  ) u_char_tag (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .rom_addr  (char_rom_addr),
    .load_tag  (char_load_tag),
    .load_data (char_load_data),
    .clr_valid (char_clr_valid),
    .mem_data  (mem_data),
    .dirty     (char_dirty),
    .data1     (char_data1),
    .data2     (char_data2)
  );

  gfx_port_tag #(
    .ADDR_W (ADDR_W)
  ) u_spr_tag (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .rom_addr  (spr_rom_addr),
    .load_tag  (spr_load_tag),
    .load_data (spr_load_data),
    .clr_valid (spr_clr_valid),
    .mem_data  (mem_data),
    .dirty     (spr_dirty),
    .data1     (spr_data1),
    .data2     (spr_data2)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wait_cnt <= '0;
      err_cnt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (char_dirty) begin
            mem_addr <= {REGION_CHAR, char_rom_addr};
            mem_req  <= 1'b1;
            wait_cnt <= TO_LOAD;
            state    <= ST_CHAR_WAIT;
          end else if (spr_dirty) begin
            mem_addr <= {REGION_SPR, spr_rom_addr};
            mem_req  <= 1'b1;
            wait_cnt <= TO_LOAD;
            state    <= ST_SPR_WAIT;
          end
        end

        ST_CHAR_WAIT, ST_SPR_WAIT: begin
          // Ack wins over a coincident terminal count.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_IDLE;
          end else if (wait_tc) begin
            mem_req <= 1'b0;
            err_cnt <= sat_inc8(err_cnt);
            state   <= ST_BACKOFF;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        ST_BACKOFF: begin
          state <= ST_IDLE;
        end

        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_rom_fetch.sv
module tb_gfx_rom_fetch;

  localparam int ADDR_W    = 13;
  localparam int ACK_DELAY = 2;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] char_rom_addr;
  logic [7:0]        char_data1, char_data2;
  logic [ADDR_W-1:0] spr_rom_addr;
  logic [7:0]        spr_data1, spr_data2;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [15:0]       mem_data;
  logic [7:0]        err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W:0] sb[$];
  logic            ack_en  = 1'b1;
  int              req_age = 0;
  logic            prev_req = 1'b0;

  always #5 clk_sys = ~clk_sys;

  gfx_rom_fetch #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (31)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .char_rom_addr (char_rom_addr),
    .char_data1    (char_data1),
    .char_data2    (char_data2),
    .spr_rom_addr  (spr_rom_addr),
    .spr_data1     (spr_data1),
    .spr_data2     (spr_data2),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .err_cnt       (err_cnt)
  );

  // ROM contents: depends on region and address so char/sprite words differ.
  function automatic logic [15:0] model(input logic [ADDR_W:0] a);
    logic [15:0] r;
    r[7:0]  = a[7:0] ^ {a[ADDR_W], 7'h15};
    r[15:8] = a[ADDR_W-1 -: 8] ^ 8'hC3;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic lvl, input string tag, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk_sys);
      cycles++;
      if (mem_req === lvl) break;
    end
    if (mem_req !== lvl) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: mem_req still %b after %0d cycles, expected %b", tag, mem_req, budget, lvl);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((sb.size() != 0 || mem_req !== 1'b0) && c < budget) begin
      @(negedge clk_sys);
      c++;
    end
    if (sb.size() != 0 || mem_req !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d requests outstanding after %0d cycles, expected 0", tag, sb.size(), budget);
    end
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic check_char(input string tag, input logic [ADDR_W:0] a);
    logic [15:0] w;
    w = model(a);
    check({tag, "_c1"}, char_data1, w[7:0]);
    check({tag, "_c2"}, char_data2, w[15:8]);
  endtask

  task automatic check_spr(input string tag, input logic [ADDR_W:0] a);
    logic [15:0] w;
    w = model(a);
    check({tag, "_s1"}, spr_data1, w[7:0]);
    check({tag, "_s2"}, spr_data2, w[15:8]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_c1"}, char_data1, 0);
    check({tag, "_c2"}, char_data2, 0);
    check({tag, "_s1"}, spr_data1, 0);
    check({tag, "_s2"}, spr_data2, 0);
    check({tag, "_err"}, err_cnt, 0);
  endtask

  // Memory responder: ack ACK_DELAY cycles after mem_req rises, when enabled.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 16'hDEAD;
    forever begin
      @(negedge clk_sys);
      if (mem_req === 1'b1) req_age++;
      else req_age = 0;
      if (mem_req === 1'b1 && ack_en && req_age == ACK_DELAY) begin
        mem_ack  = 1'b1;
        mem_data = model(mem_addr);
      end else begin
        mem_ack  = 1'b0;
        mem_data = 16'hDEAD;
      end
    end
  end

  // Request monitor: every new request must match the next expected address.
  initial begin
    logic [ADDR_W:0] exp_addr;
    forever begin
      @(negedge clk_sys);
      if (mem_req === 1'b1 && prev_req !== 1'b1) begin
        n_tests++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_req: observed addr %0h expected no request", mem_addr);
        end
        if (sb.size() > 0) begin
          exp_addr = sb.pop_front();
          check("req_addr", mem_addr, exp_addr);
        end
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_n       = 1'b0;
    char_rom_addr = 13'h0123;
    spr_rom_addr  = 13'h0456;
    repeat (2) @(negedge clk_sys);
    check_zero("reset");

    // Boot: char then sprite.
    sb.push_back({1'b0, 13'h0123});
    sb.push_back({1'b1, 13'h0456});
    reset_n = 1'b1;
    drain("boot_drain", 100);
    check_char("boot", {1'b0, 13'h0123});
    check_spr("boot", {1'b1, 13'h0456});

    // Both addresses move together: char first, exactly two requests.
    char_rom_addr = 13'h0124;
    spr_rom_addr  = 13'h0457;
    sb.push_back({1'b0, 13'h0124});
    sb.push_back({1'b1, 13'h0457});
    drain("both_drain", 100);
    check_char("both", {1'b0, 13'h0124});
    check_spr("both", {1'b1, 13'h0457});

    // Address moves mid-fetch: old data lands first, then a refetch.
    char_rom_addr = 13'h0010;
    sb.push_back({1'b0, 13'h0010});
    sb.push_back({1'b0, 13'h0011});
    wait_req(1'b1, "mid_req_hi", 20, n);
    char_rom_addr = 13'h0011;
    wait_req(1'b0, "mid_req_lo", 20, n);
    check_char("mid_old", {1'b0, 13'h0010});
    drain("mid_drain", 100);
    check_char("mid_new", {1'b0, 13'h0011});
    check_spr("mid_spr", {1'b1, 13'h0457});

    // Timeout: 31 request cycles, err_cnt=1, one backoff, same address again.
    ack_en        = 1'b0;
    char_rom_addr = 13'h0200;
    sb.push_back({1'b0, 13'h0200});
    sb.push_back({1'b0, 13'h0200});
    wait_req(1'b1, "to_req_hi", 20, n);
    wait_req(1'b0, "to_req_lo", 60, n);
    check("timeout_len", n, 31);
    check("timeout_err", err_cnt, 1);
    wait_req(1'b1, "to_retry", 20, n);
    check("backoff_gap", n, 2);
    ack_en = 1'b1;
    drain("to_drain", 100);
    check_char("retry", {1'b0, 13'h0200});
    check("retry_err", err_cnt, 1);

    // Reset during CHAR_WAIT with ack arriving in the reset cycle.
    char_rom_addr = 13'h0300;
    sb.push_back({1'b0, 13'h0300});
    wait_req(1'b1, "rst_req_hi", 20, n);
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check_zero("midrst");
    repeat (2) @(negedge clk_sys);
    check("midrst_hold_c1", char_data1, 0);
    check("midrst_hold_req", mem_req, 0);
    sb.push_back({1'b0, 13'h0300});
    sb.push_back({1'b1, 13'h0457});
    reset_n = 1'b1;
    drain("rst_drain", 100);
    check_char("post_rst", {1'b0, 13'h0300});
    check_spr("post_rst", {1'b1, 13'h0457});

    // 300 timeouts: err_cnt saturates at 255.
    ack_en        = 1'b0;
    char_rom_addr = 13'h0400;
    for (int i = 1; i <= 300; i++) begin
      sb.push_back({1'b0, 13'h0400});
      wait_req(1'b1, "sat_req_hi", 20, n);
      wait_req(1'b0, "sat_req_lo", 60, n);
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        check($sformatf("sat_err_%0d", i), err_cnt, (i > 255) ? 255 : i);
    end
    sb.push_back({1'b0, 13'h0400});
    ack_en = 1'b1;
    drain("sat_drain", 100);
    check_char("sat_final", {1'b0, 13'h0400});
    check("sat_final_err", err_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
